// File: rtl/matriz_scan_pkg.sv
// Shared definitions for the AXI4-Lite LED/key matrix scanner.
// This package holds the register offsets, the CTRL/STATUS bit positions,
// the response codes and the byte-strobe merge helper.
package matriz_scan_pkg;

  localparam logic [31:0] OFS_CTRL     = 32'h0000_0000;
  localparam logic [31:0] OFS_DWELL    = 32'h0000_0004;
  localparam logic [31:0] OFS_STATUS   = 32'h0000_0008;
  localparam logic [31:0] OFS_ROW_BASE = 32'h0000_0040;

  localparam int unsigned CTRL_EN_BIT     = 32'd0;
  localparam int unsigned CTRL_INV_BIT    = 32'd1;
  localparam int unsigned CTRL_SWAP_BIT   = 32'd2;
  localparam int unsigned STATUS_SWAP_BIT = 32'd8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_CTRL   = 3'd1,
    SEL_DWELL  = 3'd2,
    SEL_STATUS = 3'd3,
    SEL_ROW    = 3'd4
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [3:0] row;
  } reg_dec_t;

  // Merge new data into an old word, one byte lane per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/matriz_scan_engine.sv
// Row scan engine: dwell counter, row counter, frame pulse and the
// registered row_sel/col_data drive. The wrap strobe tells the register
// block when a frame boundary occurs, so it can swap buffers on that edge.
module matriz_scan_engine #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_COLS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         inv,
  input  logic [15:0]                  dwell,
  input  logic [NUM_ROWS*NUM_COLS-1:0] front,
  output logic [NUM_ROWS-1:0]          row_sel,
  output logic [NUM_COLS-1:0]          col_data,
  output logic                         frame_done,
  output logic [3:0]                   cur_row,
  output logic                         wrap
);

  localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);

  logic [15:0]         cnt_r;
  logic [3:0]          row_r;
  logic [15:0]         dwell_eff_s;
  logic                last_cnt_s;
  logic                last_row_s;
  logic [NUM_COLS-1:0] col_s;

  assign cur_row = row_r;

  // Terminal-count detection and the front-buffer column for the current row.
  always_comb begin
    dwell_eff_s = (dwell == 16'd0) ? 16'd1 : dwell;
    last_cnt_s  = (cnt_r == (dwell_eff_s - 16'd1));
    last_row_s  = (row_r == LAST_ROW);
    wrap        = en && last_cnt_s && last_row_s;
    col_s       = front[row_r*NUM_COLS +: NUM_COLS];
  end

  // Advance the scan and register the outputs one cycle behind the row counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= 16'd0;
      row_r      <= 4'd0;
      frame_done <= 1'b0;
      row_sel    <= '0;
      col_data   <= '0;
    end else if (!en) begin
      cnt_r      <= 16'd0;
      row_r      <= 4'd0;
      frame_done <= 1'b0;
      row_sel    <= '0;
      col_data   <= '0;
    end else begin
      frame_done <= wrap;
      if (last_cnt_s) begin
        cnt_r <= 16'd0;
        row_r <= last_row_s ? 4'd0 : (row_r + 4'd1);
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end
      row_sel  <= NUM_ROWS'(1) << row_r;
      col_data <= inv ? ~col_s : col_s;
    end
  end

endmodule

// File: rtl/matriz_scan_axil.sv
// AXI4-Lite register front-end for the matrix scanner. It holds the control
// registers and the double-buffered row patterns. The back buffer is
// written over the bus and copied to the front buffer at a frame boundary,
// or right away while scanning is disabled.
module matriz_scan_axil
  import matriz_scan_pkg::*;
#(
  parameter int NUM_ROWS           = 8,
  parameter int NUM_COLS           = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [NUM_ROWS-1:0]           row_sel,
  output logic [NUM_COLS-1:0]           col_data,
  output logic                          frame_done
);

  localparam int          FB_W     = NUM_ROWS * NUM_COLS;
  localparam logic [31:0] ROW_SPAN = 32'(4 * NUM_ROWS);

  logic                wr_ready_r, bvalid_r, arready_r, rvalid_r;
  logic [1:0]          bresp_r, rresp_r;
  logic [31:0]         rdata_r;
  logic                en_r, inv_r, swap_pend_r;
  logic [15:0]         dwell_r;
  logic [FB_W-1:0]     back_r, front_r;
  logic [3:0]          cur_row_s;
  logic                wrap_s;
  reg_dec_t            wdec_s, rdec_s;
  logic                wr_fire_s, rd_fire_s, wr_ok_s, swap_now_s;
  logic [31:0]         rd_data_s;
  logic [1:0]          rd_resp_s;
  logic [15:0]         dwell_new_s;
  logic [NUM_COLS-1:0] row_new_s;

  assign S_AXI_AWREADY = wr_ready_r;
  assign S_AXI_WREADY  = wr_ready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;

  // Byte address to register select; only word-aligned mapped offsets decode.
  function automatic reg_dec_t decode(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
    logic [31:0] a;
    logic [31:0] off;
    reg_dec_t    d;
    a     = 32'(addr);
    off   = a - OFS_ROW_BASE;
    d.sel = SEL_NONE;
    d.row = 4'd0;
    if (a[1:0] != 2'b00) begin
      d.sel = SEL_NONE;
    end else if (a == OFS_CTRL) begin
      d.sel = SEL_CTRL;
    end else if (a == OFS_DWELL) begin
      d.sel = SEL_DWELL;
    end else if (a == OFS_STATUS) begin
      d.sel = SEL_STATUS;
    end else if ((a >= OFS_ROW_BASE) && (off < ROW_SPAN)) begin
      d.sel = SEL_ROW;
      d.row = 4'(off >> 2);
    end else begin
      d.sel = SEL_NONE;
    end
    return d;
  endfunction

  // Address decode, handshake strobes, strobe-merged write data and read mux.
  always_comb begin
    wdec_s      = decode(S_AXI_AWADDR);
    rdec_s      = decode(S_AXI_ARADDR);
    wr_fire_s   = wr_ready_r && S_AXI_AWVALID && S_AXI_WVALID;
    rd_fire_s   = arready_r && S_AXI_ARVALID;
    wr_ok_s     = (wdec_s.sel == SEL_CTRL) || (wdec_s.sel == SEL_DWELL) ||
                  (wdec_s.sel == SEL_ROW);
    swap_now_s  = swap_pend_r && (!en_r || wrap_s);
    dwell_new_s = 16'(apply_wstrb({16'd0, dwell_r}, S_AXI_WDATA, S_AXI_WSTRB));
    row_new_s   = NUM_COLS'(apply_wstrb(32'(back_r[wdec_s.row*NUM_COLS +: NUM_COLS]),
                                        S_AXI_WDATA, S_AXI_WSTRB));
    rd_data_s   = 32'd0;
    rd_resp_s   = RESP_OKAY;
    case (rdec_s.sel)
      SEL_CTRL:   rd_data_s = {29'd0, swap_pend_r, inv_r, en_r};
      SEL_DWELL:  rd_data_s = {16'd0, dwell_r};
      SEL_STATUS: rd_data_s = {23'd0, swap_pend_r, 4'd0, cur_row_s};
      SEL_ROW:    rd_data_s = 32'(back_r[rdec_s.row*NUM_COLS +: NUM_COLS]);
      default: begin
        rd_data_s = 32'd0;
        rd_resp_s = RESP_SLVERR;
      end
    endcase
  end

  // AXI handshake state: one-cycle ready pulses, response valids held until taken.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ready_r <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rresp_r    <= RESP_OKAY;
      rdata_r    <= 32'd0;
    end else begin
      if (wr_ready_r) begin
        wr_ready_r <= 1'b0;
      end else if (S_AXI_AWVALID && S_AXI_WVALID && !bvalid_r) begin
        wr_ready_r <= 1'b1;
      end
      if (wr_fire_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_r && S_AXI_BREADY) begin
        bvalid_r <= 1'b0;
      end
      if (arready_r) begin
        arready_r <= 1'b0;
      end else if (S_AXI_ARVALID && !rvalid_r) begin
        arready_r <= 1'b1;
      end
      if (rd_fire_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_data_s;
        rresp_r  <= rd_resp_s;
      end else if (rvalid_r && S_AXI_RREADY) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  // Register file and buffers; a swap and a new swap request may share a cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      en_r        <= 1'b0;
      inv_r       <= 1'b0;
      swap_pend_r <= 1'b0;
      dwell_r     <= 16'd0;
      back_r      <= '0;
      front_r     <= '0;
    end else begin
      if (swap_now_s) begin
        front_r     <= back_r;
        swap_pend_r <= 1'b0;
      end
      if (wr_fire_s && (wdec_s.sel == SEL_CTRL) && S_AXI_WSTRB[0]) begin
        en_r  <= S_AXI_WDATA[CTRL_EN_BIT];
        inv_r <= S_AXI_WDATA[CTRL_INV_BIT];
        if (S_AXI_WDATA[CTRL_SWAP_BIT]) begin
          swap_pend_r <= 1'b1;
        end
      end
      if (wr_fire_s && (wdec_s.sel == SEL_DWELL)) begin
        dwell_r <= dwell_new_s;
      end
      if (wr_fire_s && (wdec_s.sel == SEL_ROW)) begin
        back_r[wdec_s.row*NUM_COLS +: NUM_COLS] <= row_new_s;
      end
    end
  end

  matriz_scan_engine #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS)
  ) u_engine (
    .clk        (ACLK),
    .rst        (ARESET),
    .en         (en_r),
    .inv        (inv_r),
    .dwell      (dwell_r),
    .front      (front_r),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_done (frame_done),
    .cur_row    (cur_row_s),
    .wrap       (wrap_s)
  );

endmodule

// File: tb/tb_matriz_scan_axil.sv
// Self-checking bench for matriz_scan_axil (8 rows x 8 columns).
module tb_matriz_scan_axil;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [6:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [7:0]  row_sel, col_data;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {logic [31:0] data; logic [1:0] resp;} rd_exp_t;
  typedef struct {logic wr; logic [6:0] addr; logic [31:0] wdata; logic [3:0] strb;
                  logic [31:0] exp; logic [1:0] resp;} op_t;
  typedef struct {logic [7:0] rs; logic [7:0] cd; logic fd;} scan_exp_t;

  rd_exp_t   rd_q[$];
  logic [1:0] wr_q[$];
  scan_exp_t scan_q[$];

  matriz_scan_axil #(.NUM_ROWS(8), .NUM_COLS(8), .C_S_AXI_ADDR_WIDTH(7)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .row_sel(row_sel), .col_data(col_data), .frame_done(frame_done)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int t;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    t = 0;
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && t < 20) begin tick(); t++; end
    if (t >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL wr_ready addr=%h: got no AWREADY/WREADY, required within 20 cycles", addr);
    end
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    t = 0;
    while (!S_AXI_BVALID && t < 20) begin tick(); t++; end
    if (t >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL bvalid addr=%h: got no BVALID, required within 20 cycles", addr);
    end
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [6:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int t;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    t = 0;
    while (!S_AXI_ARREADY && t < 20) begin tick(); t++; end
    if (t >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL rd_ready addr=%h: got no ARREADY, required within 20 cycles", addr);
    end
    tick();
    S_AXI_ARVALID = 1'b0;
    t = 0;
    while (!S_AXI_RVALID && t < 20) begin tick(); t++; end
    if (t >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL rvalid addr=%h: got no RVALID, required within 20 cycles", addr);
    end
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int t = 0;
    while (!frame_done && t < 100) begin tick(); t++; end
    if (t >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL %s_frame: got no frame_done, required within 100 cycles", tag);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic [1:0] rr; rd_exp_t e;
    logic [6:0] addrs[3] = '{7'h00, 7'h04, 7'h08};
    n_cmp++;
    if ({row_sel, col_data, frame_done, S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rs=%h cd=%h fd=%b bv=%b rv=%b, required all 0",
               row_sel, col_data, frame_done, S_AXI_BVALID, S_AXI_RVALID);
    end
    foreach (addrs[i]) begin
      rd_q.push_back('{32'h0, 2'b00});
      axi_read(addrs[i], rd, rr);
      e = rd_q.pop_front();
      n_cmp++;
      if ({rd, rr} !== {e.data, e.resp}) begin
        n_err++;
        $display("FAIL reset_reg addr=%h: got %h/%b, required %h/%b", addrs[i], rd, rr, e.data, e.resp);
      end
    end
  endtask

  task automatic test_rows();
    op_t ops[$]; logic [31:0] rd; logic [1:0] rr, br, eb; rd_exp_t e;
    for (int i = 0; i < 4; i++) ops.push_back('{1'b1, 7'(32'h40 + 4*i), 32'(i+1), 4'hF, 32'h0, 2'b00});
    for (int i = 0; i < 8; i++) ops.push_back('{1'b0, 7'(32'h40 + 4*i), 32'h0, 4'h0,
                                                  (i < 4) ? 32'(i+1) : 32'h0, 2'b00});
    foreach (ops[i]) begin
      if (ops[i].wr) begin
        wr_q.push_back(ops[i].resp);
        axi_write(ops[i].addr, ops[i].wdata, ops[i].strb, br);
        eb = wr_q.pop_front();
        n_cmp++;
        if (br !== eb) begin n_err++; $display("FAIL rows_bresp addr=%h: got %b, required %b", ops[i].addr, br, eb); end
      end else begin
        rd_q.push_back('{ops[i].exp, ops[i].resp});
        axi_read(ops[i].addr, rd, rr);
        e = rd_q.pop_front();
        n_cmp++;
        if ({rd, rr} !== {e.data, e.resp}) begin
          n_err++; $display("FAIL rows_read addr=%h: got %h/%b, required %h/%b", ops[i].addr, rd, rr, e.data, e.resp);
        end
      end
    end
  endtask

  task automatic test_unmapped();
    op_t ops[$]; logic [31:0] rd; logic [1:0] rr, br, eb; rd_exp_t e;
    ops.push_back('{1'b0, 7'h60, 32'h0, 4'h0, 32'h0, 2'b10});
    ops.push_back('{1'b0, 7'h0C, 32'h0, 4'h0, 32'h0, 2'b10});
    ops.push_back('{1'b0, 7'h41, 32'h0, 4'h0, 32'h0, 2'b10});
    ops.push_back('{1'b1, 7'h08, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10});
    ops.push_back('{1'b1, 7'h60, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10});
    ops.push_back('{1'b1, 7'h10, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10});
    ops.push_back('{1'b0, 7'h08, 32'h0, 4'h0, 32'h0, 2'b00});
    ops.push_back('{1'b0, 7'h00, 32'h0, 4'h0, 32'h0, 2'b00});
    ops.push_back('{1'b0, 7'h40, 32'h0, 4'h0, 32'h1, 2'b00});
    ops.push_back('{1'b0, 7'h5C, 32'h0, 4'h0, 32'h0, 2'b00});
    foreach (ops[i]) begin
      if (ops[i].wr) begin
        wr_q.push_back(ops[i].resp);
        axi_write(ops[i].addr, ops[i].wdata, ops[i].strb, br);
        eb = wr_q.pop_front();
        n_cmp++;
        if (br !== eb) begin n_err++; $display("FAIL unmapped_bresp addr=%h: got %b, required %b", ops[i].addr, br, eb); end
      end else begin
        rd_q.push_back('{ops[i].exp, ops[i].resp});
        axi_read(ops[i].addr, rd, rr);
        e = rd_q.pop_front();
        n_cmp++;
        if ({rd, rr} !== {e.data, e.resp}) begin
          n_err++; $display("FAIL unmapped_read addr=%h: got %h/%b, required %h/%b", ops[i].addr, rd, rr, e.data, e.resp);
        end
      end
    end
  endtask

  task automatic test_wstrb();
    op_t ops[$]; logic [31:0] rd; logic [1:0] rr, br; rd_exp_t e;
    ops.push_back('{1'b1, 7'h54, 32'h0000_0000, 4'hF, 32'h0, 2'b00});
    ops.push_back('{1'b1, 7'h54, 32'hFFFF_FFFF, 4'h1, 32'h0, 2'b00});
    ops.push_back('{1'b0, 7'h54, 32'h0, 4'h0, 32'h0000_00FF, 2'b00});
    ops.push_back('{1'b1, 7'h58, 32'h1234_5678, 4'hF, 32'h0, 2'b00});
    ops.push_back('{1'b0, 7'h58, 32'h0, 4'h0, 32'h0000_0078, 2'b00});
    ops.push_back('{1'b1, 7'h58, 32'hFFFF_FF00, 4'hE, 32'h0, 2'b00});
    ops.push_back('{1'b0, 7'h58, 32'h0, 4'h0, 32'h0000_0078, 2'b00});
    ops.push_back('{1'b1, 7'h04, 32'hAABB_CCDD, 4'h2, 32'h0, 2'b00});
    ops.push_back('{1'b0, 7'h04, 32'h0, 4'h0, 32'h0000_CC00, 2'b00});
    ops.push_back('{1'b1, 7'h00, 32'hFFFF_FFF8, 4'hE, 32'h0, 2'b00});
    ops.push_back('{1'b0, 7'h00, 32'h0, 4'h0, 32'h0000_0000, 2'b00});
    foreach (ops[i]) begin
      if (ops[i].wr) begin
        axi_write(ops[i].addr, ops[i].wdata, ops[i].strb, br);
      end else begin
        rd_q.push_back('{ops[i].exp, ops[i].resp});
        axi_read(ops[i].addr, rd, rr);
        e = rd_q.pop_front();
        n_cmp++;
        if ({rd, rr} !== {e.data, e.resp}) begin
          n_err++; $display("FAIL wstrb_read addr=%h: got %h/%b, required %h/%b", ops[i].addr, rd, rr, e.data, e.resp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic [1:0] rr, br; rd_exp_t e; int t;
    axi_write(7'h04, 32'h0000_0005, 4'hF, br);
    rd_q.push_back('{32'h0000_0005, 2'b00});
    S_AXI_AWADDR = 7'h04; S_AXI_WDATA = 32'h0000_0009; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 7'h04; S_AXI_ARVALID = 1'b1;
    t = 0;
    while (!(S_AXI_AWREADY && S_AXI_ARREADY) && t < 20) begin tick(); t++; end
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    while (!(S_AXI_BVALID && S_AXI_RVALID) && t < 40) begin tick(); t++; end
    rd = S_AXI_RDATA; rr = S_AXI_RRESP; br = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    e = rd_q.pop_front();
    n_cmp++;
    if (t >= 40 || {rd, rr, br} !== {e.data, e.resp, 2'b00}) begin
      n_err++; $display("FAIL b2b_read: got %h/%b bresp=%b t=%0d, required %h/%b bresp=00", rd, rr, br, t, e.data, e.resp);
    end
    rd_q.push_back('{32'h0000_0009, 2'b00});
    axi_read(7'h04, rd, rr);
    e = rd_q.pop_front();
    n_cmp++;
    if ({rd, rr} !== {e.data, e.resp}) begin
      n_err++; $display("FAIL b2b_after: got %h/%b, required %h/%b", rd, rr, e.data, e.resp);
    end
  endtask

  task automatic test_scan();
    logic [31:0] rd; logic [1:0] rr, br; rd_exp_t e; scan_exp_t s; int row, idx;
    for (int r = 0; r < 8; r++) axi_write(7'(32'h40 + 4*r), 32'(8'h10 + r), 4'hF, br);
    axi_write(7'h00, 32'h4, 4'hF, br);
    repeat (2) tick();
    rd_q.push_back('{32'h0, 2'b00});
    axi_read(7'h00, rd, rr);
    e = rd_q.pop_front();
    n_cmp++;
    if ({rd, rr} !== {e.data, e.resp}) begin
      n_err++; $display("FAIL idle_swap_ctrl: got %h/%b, required %h/%b", rd, rr, e.data, e.resp);
    end
    axi_write(7'h04, 32'h3, 4'hF, br);
    axi_write(7'h00, 32'h1, 4'hF, br);
    wait_frame("scan");
    for (int c = 1; c <= 48; c++) begin
      row = ((c - 1) / 3) % 8;
      scan_q.push_back('{8'(1 << row), 8'(8'h10 + row), (c % 24) == 0});
    end
    for (int c = 1; c <= 48; c++) begin
      tick();
      s = scan_q.pop_front();
      n_cmp++;
      if ({row_sel, col_data, frame_done} !== {s.rs, s.cd, s.fd}) begin
        n_err++; $display("FAIL scan c=%0d: got rs=%h cd=%h fd=%b, required rs=%h cd=%h fd=%b",
                          c, row_sel, col_data, frame_done, s.rs, s.cd, s.fd);
      end
    end
    axi_write(7'h00, 32'h3, 4'hF, br);
    tick();
    idx = -1;
    for (int r = 0; r < 8; r++) if (row_sel == 8'(1 << r)) idx = r;
    n_cmp++;
    if (idx < 0 || col_data !== ~8'(8'h10 + idx)) begin
      n_err++; $display("FAIL inv: got rs=%h cd=%h, required one-hot rs and cd=~(0x10+row)", row_sel, col_data);
    end
    axi_write(7'h00, 32'h0, 4'hF, br);
    repeat (2) tick();
    n_cmp++;
    if ({row_sel, col_data} !== 16'h0) begin
      n_err++; $display("FAIL disable: got rs=%h cd=%h, required 00/00", row_sel, col_data);
    end
    rd_q.push_back('{32'h0, 2'b00});
    axi_read(7'h08, rd, rr);
    e = rd_q.pop_front();
    n_cmp++;
    if ({rd, rr} !== {e.data, e.resp}) begin
      n_err++; $display("FAIL disable_status: got %h/%b, required %h/%b", rd, rr, e.data, e.resp);
    end
  endtask

  task automatic test_swap();
    logic [31:0] rd; logic [1:0] rr, br; rd_exp_t e; scan_exp_t s; int t, idx, viol;
    axi_write(7'h00, 32'h1, 4'hF, br);
    wait_frame("swap_sync");
    axi_write(7'h40, 32'hAA, 4'hF, br);
    axi_write(7'h00, 32'h5, 4'hF, br);
    axi_read(7'h08, rd, rr);
    n_cmp++;
    if ((rd & 32'h100) !== 32'h100 || rr !== 2'b00) begin
      n_err++; $display("FAIL swap_pending: got %h/%b, required bit8=1/00", rd, rr);
    end
    viol = 0; t = 0;
    while (!frame_done && t < 40) begin
      idx = -1;
      for (int r = 0; r < 8; r++) if (row_sel == 8'(1 << r)) idx = r;
      if (idx < 0 || col_data !== 8'(8'h10 + idx)) viol++;
      tick(); t++;
    end
    n_cmp++;
    if (viol != 0 || t >= 40) begin
      n_err++; $display("FAIL swap_hold: got %0d bad cycles t=%0d, required 0 before frame_done", viol, t);
    end
    for (int c = 1; c <= 3; c++) scan_q.push_back('{8'h01, 8'hAA, 1'b0});
    scan_q.push_back('{8'h02, 8'h11, 1'b0});
    for (int c = 1; c <= 4; c++) begin
      tick();
      s = scan_q.pop_front();
      n_cmp++;
      if ({row_sel, col_data, frame_done} !== {s.rs, s.cd, s.fd}) begin
        n_err++; $display("FAIL swap_new c=%0d: got rs=%h cd=%h fd=%b, required rs=%h cd=%h fd=%b",
                          c, row_sel, col_data, frame_done, s.rs, s.cd, s.fd);
      end
    end
    rd_q.push_back('{32'h1, 2'b00});
    axi_read(7'h00, rd, rr);
    e = rd_q.pop_front();
    n_cmp++;
    if ({rd, rr} !== {e.data, e.resp}) begin
      n_err++; $display("FAIL swap_cleared: got %h/%b, required %h/%b", rd, rr, e.data, e.resp);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] rd; logic [1:0] rr; rd_exp_t e; int t, bad;
    logic [6:0] addrs[4] = '{7'h00, 7'h04, 7'h08, 7'h40};
    S_AXI_AWADDR = 7'h04; S_AXI_WDATA = 32'h7; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    t = 0;
    while (!S_AXI_AWREADY && t < 20) begin tick(); t++; end
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    while (!S_AXI_BVALID && t < 40) begin tick(); t++; end
    n_cmp++;
    if (!(S_AXI_BVALID === 1'b1 && $onehot(row_sel))) begin
      n_err++; $display("FAIL pre_reset: got bv=%b rs=%h, required bv=1 and one-hot rs", S_AXI_BVALID, row_sel);
    end
    #2 ARESET = 1'b1;
    #1;
    n_cmp++;
    if ({S_AXI_BVALID, S_AXI_RVALID, row_sel, col_data, frame_done} !== 19'd0) begin
      n_err++; $display("FAIL async_reset: got bv=%b rs=%h cd=%h, required all 0", S_AXI_BVALID, row_sel, col_data);
    end
    repeat (2) tick();
    ARESET = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (S_AXI_BVALID || S_AXI_RVALID || S_AXI_AWREADY || S_AXI_ARREADY) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL post_reset_idle: got %0d cycles with activity, required 0", bad);
    end
    foreach (addrs[i]) begin
      rd_q.push_back('{32'h0, 2'b00});
      axi_read(addrs[i], rd, rr);
      e = rd_q.pop_front();
      n_cmp++;
      if ({rd, rr} !== {e.data, e.resp}) begin
        n_err++; $display("FAIL post_reset_reg addr=%h: got %h/%b, required %h/%b", addrs[i], rd, rr, e.data, e.resp);
      end
    end
  endtask

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = 7'h0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0;
    S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = 7'h0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    repeat (3) tick();
    ARESET = 1'b0;
    tick();
    test_reset();
    test_rows();
    test_unmapped();
    test_wstrb();
    test_back_to_back();
    test_scan();
    test_swap();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matriz_scan_axil.md
MATRIZ_SCAN_AXIL -- requirements
Module: matriz_scan_axil

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 8, number of matrix rows (legal 1..16).
REQ-002 SHALL have parameter NUM_COLS, default 8, number of matrix columns (legal 1..32).
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 7, AXI4-Lite byte address width; data width fixed at 32.
REQ-004 SHALL have port ACLK, input, 1, sole clock.
REQ-005 SHALL have port ARESET, input, 1, asynchronous active-high reset.
REQ-006 SHALL have AXI4-Lite slave ports S_AXI_AW*/W*/B*/AR*/R*, standard directions and widths (WSTRB 4, BRESP/RRESP 2).
REQ-007 SHALL have port row_sel, output, NUM_ROWS, one-hot active row.
REQ-008 SHALL have port col_data, output, NUM_COLS, column pattern for active row.
REQ-009 SHALL have port frame_done, output, 1, single-cycle pulse on frame completion.

Function
REQ-010 SHALL map: 0x00 CTRL (bit0 EN, bit1 INV, bit2 SWAP), 0x04 DWELL[15:0], 0x08 STATUS (RO: [3:0] current row, bit8 swap pending), 0x40+4*r back-buffer row r, r < NUM_ROWS.
REQ-011 SHALL accept a write only when AWVALID and WVALID are both high and BVALID is low; AWREADY and WREADY pulse together for one cycle.
REQ-012 SHALL assert BVALID the cycle after acceptance and hold it until BREADY.
REQ-013 SHALL pulse ARREADY for one cycle when ARVALID is high and RVALID is low; RVALID rises the next cycle and holds until RREADY.
REQ-014 SHALL apply WSTRB per byte; row registers retain only bits [NUM_COLS-1:0]; unused bits read 0.
REQ-015 SHALL respond SLVERR (2'b10) to any unmapped access, including rows >= NUM_ROWS and writes to STATUS; unmapped writes change no state, unmapped reads return 0.
REQ-016 SHALL serve a read and a write in the same cycle independently; a read of a register written in that cycle returns the pre-write value.
REQ-017 SHALL, with EN=1, count DWELL cycles per row (DWELL=0 treated as 1), then advance row; row NUM_ROWS-1 wraps to 0.
REQ-018 SHALL pulse frame_done in the cycle row wraps from NUM_ROWS-1 to 0.
REQ-019 SHALL drive row_sel = one-hot(row) and col_data = front[row] (bitwise inverted when INV=1), registered, one cycle after row change.
REQ-020 SHALL, with EN=0, drive row_sel and col_data to 0 and hold row and dwell counter at 0.
REQ-021 SHALL set swap-pending when CTRL is written with bit2=1; bit2 reads back as swap-pending.
REQ-022 SHALL copy the entire back buffer into the front buffer at the frame_done cycle if swap-pending, then clear swap-pending in the same cycle.
REQ-023 SHALL, with EN=0, perform a pending swap on the cycle after the request.
REQ-024 SHALL restart the scan at row 0 with a cleared dwell counter when EN goes 0->1.

Reset
REQ-025 SHALL, on ARESET, clear all registers, both buffers, swap-pending, row and dwell counters asynchronously.
REQ-026 SHALL hold all AXI READY/VALID outputs, row_sel, col_data and frame_done at 0 while ARESET is high.
REQ-027 SHALL abandon any in-flight AXI transaction on reset; no BVALID/RVALID after release without a new request.

Structure
REQ-028 SHALL take register offsets, CTRL bit positions and response codes from shared package matriz_scan_pkg.
REQ-029 SHALL place the dwell counter, row counter, frame_done and output registers in sub-module matriz_scan_engine.

Verification
REQ-030 SHALL cover: write 0x40..0x4C with 1..4 and read back -> RDATA 1..4, RRESP OKAY.
REQ-031 SHALL cover: read 0x40+4*NUM_ROWS and write 0x08 -> SLVERR, no state change.
REQ-032 SHALL cover: DWELL=3, EN=1, NUM_ROWS=8 -> each row_sel one-hot for 3 cycles, frame_done every 24 cycles.
REQ-033 SHALL cover: scanning, write back row 0 = 0xAA, SWAP mid-frame -> col_data unchanged until frame_done, 0xAA on next row-0 period.
REQ-034 SHALL cover: WSTRB=4'b0001 writing 0xFFFFFFFF over row value 0x00 -> row reads 0xFF (NUM_COLS=8).
REQ-035 SHALL cover: ARESET asserted with BVALID pending -> BVALID, row_sel, col_data to 0 immediately; registers read 0 after release.
